// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue/writeback controller in front of a 32-bit MIPS ALU.
//   It accepts one instruction at a time and decodes it into an ALU function code
//   and operands. After one settle cycle it captures the ALU result and Z flag, then
//   holds a writeback/branch result until the consumer accepts it. It also owns
//   the HI/LO registers.
//
// Ports
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   in_valid_i      instruction/operands valid
//   in_ready_o      controller can accept an instruction (IDLE only)
//   instr_i         MIPS instruction word
//   rs_val_i        value of register rs
//   rt_val_i        value of register rt
//   alu_func_o      6-bit ALU function code
//   alu_a_o         ALU operand a
//   alu_b_o         ALU operand b
//   alu_result_i    ALU result (combinational from func/a/b)
//   alu_z_i         ALU zero flag
//   wb_valid_o      writeback/branch result valid
//   wb_ready_i      consumer accepts result
//   wb_we_o         register-file write enable
//   wb_rd_o         destination register
//   wb_data_o       write data
//   branch_taken_o  branch decision
//   illegal_o       unsupported encoding
module alu_issue_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic [5:0]  alu_func_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_z_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        branch_taken_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;
  // BR_Z covers BGTZ/BLEZ: the ALU reports the condition through its Z flag.
  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE, BR_Z} br_e;

  state_e      state_q, state_d;
  br_e         br_q, br_d;
  logic        mov_q, mov_d;
  logic        hi_wr_q, hi_wr_d;
  logic        lo_wr_q, lo_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [5:0]  alu_func_q, alu_func_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        branch_taken_q, branch_taken_d;
  logic        illegal_q, illegal_d;

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs_f, rt_f, rd_f, shamt;
  logic [15:0] imm;
  assign opcode = instr_i[31:26];
  assign rs_f   = instr_i[25:21];
  assign rt_f   = instr_i[20:16];
  assign rd_f   = instr_i[15:11];
  assign shamt  = instr_i[10:6];
  assign funct  = instr_i[5:0];
  assign imm    = instr_i[15:0];

  // Decoded instruction (valid while in_valid_i in IDLE)
  logic [5:0]  dec_func;
  logic [31:0] dec_a, dec_b;
  logic [4:0]  dec_rd;
  logic        dec_we, dec_ill, dec_hi, dec_lo, dec_mov;
  br_e         dec_br;

  always_comb begin
    dec_func = 6'b000000;
    dec_a    = 32'h0;
    dec_b    = 32'h0;
    dec_rd   = 5'd0;
    dec_we   = 1'b0;
    dec_ill  = 1'b0;
    dec_hi   = 1'b0;
    dec_lo   = 1'b0;
    dec_mov  = 1'b0;
    dec_br   = BR_NONE;
    unique case (opcode)
      6'b000000: begin
        dec_rd = rd_f;
        dec_we = 1'b1;
        unique case (funct)
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b101010, 6'b101011: begin
            dec_func = funct;
            dec_a    = rs_val_i;
            dec_b    = rt_val_i;
          end
          6'b000000: begin dec_func = 6'b000100; dec_a = rt_val_i; dec_b = {27'b0, shamt}; end
          6'b000010: begin dec_func = 6'b000110; dec_a = rt_val_i; dec_b = {27'b0, shamt}; end
          6'b000011: begin dec_func = 6'b000011; dec_a = rt_val_i; dec_b = {27'b0, shamt}; end
          6'b000100: begin dec_func = 6'b000100; dec_a = rt_val_i; dec_b = {27'b0, rs_val_i[4:0]}; end
          6'b000110: begin dec_func = 6'b000110; dec_a = rt_val_i; dec_b = {27'b0, rs_val_i[4:0]}; end
          6'b000111: begin dec_func = 6'b000011; dec_a = rt_val_i; dec_b = {27'b0, rs_val_i[4:0]}; end
          6'b010000: begin dec_func = 6'b010000; dec_a = hi_q; end
          6'b010010: begin dec_func = 6'b010010; dec_a = lo_q; end
          // MTHI/MTLO: rs rides in alu_a until the writeback handshake commits it.
          6'b010001: begin dec_func = 6'b100101; dec_a = rs_val_i; dec_we = 1'b0; dec_hi = 1'b1; end
          6'b010011: begin dec_func = 6'b100101; dec_a = rs_val_i; dec_we = 1'b0; dec_lo = 1'b1; end
          6'b001011: begin dec_func = 6'b100101; dec_a = rs_val_i; dec_mov = 1'b1; dec_we = (rt_val_i != 32'h0); end
          6'b001010: begin dec_func = 6'b100101; dec_a = rs_val_i; dec_mov = 1'b1; dec_we = (rt_val_i == 32'h0); end
          default:   begin dec_ill = 1'b1; dec_we = 1'b0; end
        endcase
      end
      6'b011100: begin
        dec_rd = rd_f;
        dec_we = 1'b1;
        dec_a  = rs_val_i;
        unique case (funct)
          6'b100001: dec_func = 6'b111000;
          6'b100000: dec_func = 6'b000111;
          default:   begin dec_ill = 1'b1; dec_we = 1'b0; dec_a = 32'h0; end
        endcase
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
        dec_rd = rt_f;
        dec_we = 1'b1;
        dec_a  = rs_val_i;
        dec_b  = {{16{imm[15]}}, imm};
        unique case (opcode[1:0])
          2'b00:   dec_func = 6'b100000;
          2'b01:   dec_func = 6'b100001;
          2'b10:   dec_func = 6'b101010;
          default: dec_func = 6'b101011;
        endcase
      end
      6'b001100, 6'b001101, 6'b001110: begin
        dec_rd = rt_f;
        dec_we = 1'b1;
        dec_a  = rs_val_i;
        dec_b  = {16'h0, imm};
        unique case (opcode[1:0])
          2'b00:   dec_func = 6'b100100;
          2'b01:   dec_func = 6'b100101;
          default: dec_func = 6'b100110;
        endcase
      end
      6'b001111: begin
        dec_rd   = rt_f;
        dec_we   = 1'b1;
        dec_func = 6'b100101;
        dec_b    = {imm, 16'h0};
      end
      6'b000100: begin dec_br = BR_EQ; dec_func = 6'b100010; dec_a = rs_val_i; dec_b = rt_val_i; end
      6'b000101: begin dec_br = BR_NE; dec_func = 6'b100010; dec_a = rs_val_i; dec_b = rt_val_i; end
      6'b000111: begin dec_br = BR_Z;  dec_func = 6'b110010; dec_a = rs_val_i; end
      6'b000110: begin dec_br = BR_Z;  dec_func = 6'b110110; dec_a = rs_val_i; end
      default:   dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    br_d           = br_q;
    mov_d          = mov_q;
    hi_wr_d        = hi_wr_q;
    lo_wr_d        = lo_wr_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    alu_func_d     = alu_func_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    wb_valid_d     = wb_valid_q;
    wb_we_d        = wb_we_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    branch_taken_d = branch_taken_q;
    illegal_d      = illegal_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          alu_func_d = dec_func;
          alu_a_d    = dec_a;
          alu_b_d    = dec_b;
          // wb_we/wb_rd/illegal may change early: they are only meaningful with wb_valid.
          wb_we_d    = dec_we && (dec_rd != 5'd0);
          wb_rd_d    = dec_rd;
          illegal_d  = dec_ill;
          br_d       = dec_br;
          mov_d      = dec_mov;
          hi_wr_d    = dec_hi;
          lo_wr_d    = dec_lo;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (illegal_q)  wb_data_d = 32'h0;
        else if (mov_q) wb_data_d = alu_a_q;
        else            wb_data_d = alu_result_i;
        unique case (br_q)
          BR_EQ:   branch_taken_d = alu_z_i;
          BR_NE:   branch_taken_d = !alu_z_i;
          BR_Z:    branch_taken_d = alu_z_i;
          default: branch_taken_d = 1'b0;
        endcase
        wb_valid_d = 1'b1;
        state_d    = S_WB;
      end
      S_WB: begin
        if (wb_ready_i) begin
          wb_valid_d = 1'b0;
          if (hi_wr_q) hi_d = alu_a_q;
          if (lo_wr_q) lo_d = alu_a_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      br_q           <= BR_NONE;
      mov_q          <= 1'b0;
      hi_wr_q        <= 1'b0;
      lo_wr_q        <= 1'b0;
      hi_q           <= 32'h0;
      lo_q           <= 32'h0;
      alu_func_q     <= 6'h0;
      alu_a_q        <= 32'h0;
      alu_b_q        <= 32'h0;
      wb_valid_q     <= 1'b0;
      wb_we_q        <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= 32'h0;
      branch_taken_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      br_q           <= br_d;
      mov_q          <= mov_d;
      hi_wr_q        <= hi_wr_d;
      lo_wr_q        <= lo_wr_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      alu_func_q     <= alu_func_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      wb_valid_q     <= wb_valid_d;
      wb_we_q        <= wb_we_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      branch_taken_q <= branch_taken_d;
      illegal_q      <= illegal_d;
    end
  end

  assign in_ready_o     = (state_q == S_IDLE);
  assign alu_func_o     = alu_func_q;
  assign alu_a_o        = alu_a_q;
  assign alu_b_o        = alu_b_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_we_o        = wb_we_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign branch_taken_o = branch_taken_q;
  assign illegal_o      = illegal_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/writeback controller that drives the 32-bit MIPS ALU. It accepts one decoded-register instruction at a time and translates the opcode/funct into the ALU's 6-bit function code and operands. It captures the ALU result and zero flag, then presents a register-file writeback or branch decision. It sits between the register-read stage and the register file and owns the HI/LO registers and the MOVN/MOVZ write-enable logic.

## Interface

No parameters (the ALU interface is fixed at 32-bit data and a 6-bit function code).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  instruction/operands valid
- in_ready  out  1  controller can accept an instruction
- instr  in  32  MIPS instruction word
- rs_val  in  32  register value of rs
- rt_val  in  32  register value of rt
- alu_func  out  6  function code to the ALU
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_result  in  32  ALU result (combinational from alu_func/a/b)
- alu_z  in  1  ALU Z_flag
- wb_valid  out  1  writeback/branch result valid
- wb_ready  in  1  consumer accepts result
- wb_we  out  1  register-file write enable (qualified by wb_valid)
- wb_rd  out  5  destination register
- wb_data  out  32  write data
- branch_taken  out  1  branch decision (qualified by wb_valid)
- illegal  out  1  unsupported encoding (qualified by wb_valid)

## Operation

- FSM states: IDLE, EXEC, WB.
  - IDLE: in_ready=1. The handshake in_valid&in_ready latches instr/rs_val/rt_val, registers decoded alu_func/alu_a/alu_b, and moves to EXEC.
  - EXEC: one settle cycle with ALU inputs stable. At the end edge, latch alu_result/alu_z into wb_data/branch_taken, set wb_valid, and move to WB.
  - WB: hold all wb_* outputs stable until wb_ready. On wb_valid&wb_ready, return to IDLE; HI/LO writes commit on this edge.
- R-type decode (opcode 000000), dest=rd:
  - AND/OR/XOR/NOR/ADD/ADDU/SUB/SUBU/SLT/SLTU: func=funct, a=rs, b=rt.
  - SLL/SRL/SRA (funct 000000/000010/000011): func=000100/000110/000011, a=rt, b=zero-extended shamt.
  - SLLV/SRLV/SRAV (000100/000110/000111): func=000100/000110/000011, a=rt, b={27'b0, rs[4:0]}.
  - MFHI/MFLO: func=010000/010010, a=HI/LO.
  - MTHI/MTLO (010001/010011): wb_we=0; HI/LO<=rs at commit.
  - MOVN/MOVZ (001011/001010): wb_data=rs, wb_we=(rt!=0)/(rt==0); ALU not used (func=100101, a=rs, b=0).
- SPECIAL2 (opcode 011100): CLO funct 100001 → func 111000, CLZ funct 100000 → func 000111, a=rs, dest=rd.
- I-type, dest=rt:
  - ADDI→100000, ADDIU→100001, SLTI→101010, SLTIU→101011, all with b=sign-extended imm.
  - ANDI→100100, ORI→100101, XORI→100110, all with b=zero-extended imm.
  - LUI: func=100101, a=0, b={imm,16'h0}.
- Branches (wb_we=0):
  - BEQ/BNE: func=100010, a=rs, b=rt, taken=alu_z / !alu_z.
  - BGTZ: func=110010, a=rs, taken=alu_z.
  - BLEZ: func=110110, a=rs, taken=alu_z.
- Any other encoding: illegal=1, wb_we=0, branch_taken=0, still completes through WB.
- Destination register 0 forces wb_we=0.
- branch_taken=0 for non-branches; illegal=0 for legal encodings.

## Timing

- Reset (async, rst_n low): state=IDLE, HI=LO=0, and alu_func, alu_a, alu_b, wb_valid, wb_we, wb_rd, wb_data, branch_taken, illegal all 0. in_ready=1 once IDLE.
- Latency: an instruction accepted at edge N gives stable ALU inputs during cycle N+1; wb_valid goes high after edge N+1 (2 cycles). Peak throughput is 1 instruction per 3 cycles with wb_ready tied high.
- in_ready=0 in EXEC and WB; in_valid is ignored there and the instruction is not consumed.
- Backpressure: while wb_valid&!wb_ready, all wb_* outputs, alu_* outputs, HI and LO are held unchanged.
- MTHI/MTLO followed by MFHI/MFLO returns the new value, since the commit precedes the next acceptance.
- rst_n asserted in EXEC/WB abandons the instruction: no HI/LO update, wb_valid drops immediately.

## Test plan

- ADDI instr=0x2022FFFF, rs_val=5 → alu_func=100000, alu_b=0xFFFFFFFF; 2 cycles later wb_valid=1, wb_rd=2, wb_data=4, wb_we=1.
- SLL instr=0x00032100, rt_val=1 → alu_func=000100, a=1, b=4; wb_rd=4, wb_data=0x10.
- MOVZ rd=5 with rt_val=7 → wb_we=0. Repeat with rt_val=0, rs_val=0xABCD → wb_we=1, wb_data=0xABCD.
- BEQ rs_val=rt_val=0x55 → func=100010, branch_taken=1, wb_we=0. BNE with the same operands → branch_taken=0.
- MTHI rs_val=0x1234 then MFHI rd=8 → wb_data=0x1234. Holding wb_ready=0 for 3 cycles on the MTHI keeps HI=0 and in_ready=0 until the handshake.
- Opcode 111111 → illegal=1, wb_we=0. Asserting rst_n=0 during EXEC of ADDU → all outputs 0 next cycle, no writeback issued.
